// File: rtl/cam_cfg_pkg.sv
// ---------------------------------------------------------------------------
// cam_cfg_pkg
// Shared definitions for the camera SCCB register-programming path:
//   - reg_entry_t    : one (sub-address, data) table entry
//   - SCCB_WR_ADDR   : default 8-bit SCCB device write address
//   - seq_state_e    : sequencer FSM state encoding
//   - cfg_entry()    : default OV-series initialisation table lookup
// ---------------------------------------------------------------------------
package cam_cfg_pkg;

    typedef struct packed {
        logic [7:0] sub_addr;
        logic [7:0] data;
    } reg_entry_t;

    localparam logic [7:0] SCCB_WR_ADDR = 8'hC0;

    localparam int unsigned CFG_TABLE_LEN = 8;

    typedef enum logic [3:0] {
        StIdle,
        StArm,
        StIssueWr,
        StWaitWr,
        StIssueRd,
        StWaitRd,
        StNext,
        StDone,
        StFail
    } seq_state_e;

    // Default OV-series table; indices past the end read as all-zero.
    function automatic reg_entry_t cfg_entry(input int unsigned idx);
        reg_entry_t e;
        case (idx)
            0:       e = '{sub_addr: 8'h11, data: 8'h04};
            1:       e = '{sub_addr: 8'h14, data: 8'h20};
            2:       e = '{sub_addr: 8'h39, data: 8'h40};
            3:       e = '{sub_addr: 8'h28, data: 8'hE0};
            4:       e = '{sub_addr: 8'h17, data: 8'h38};
            5:       e = '{sub_addr: 8'h18, data: 8'h6A};
            6:       e = '{sub_addr: 8'h19, data: 8'h03};
            7:       e = '{sub_addr: 8'h1A, data: 8'h35};
            default: e = '{sub_addr: 8'h00, data: 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// ---------------------------------------------------------------------------
// sccb_init_rom
// Combinational register-table lookup. Swap this file to retarget a sensor.
// Ports:
//   i_idx   : table index
//   o_entry : (sub_addr, data) pair for i_idx; zero beyond NUM_REGS-1
// ---------------------------------------------------------------------------
module sccb_init_rom
    import cam_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8
) (
    input  logic [$clog2(NUM_REGS):0] i_idx,
    output reg_entry_t                o_entry
);

    always_comb begin
        if (32'(i_idx) < NUM_REGS) begin
            o_entry = cfg_entry(32'(i_idx));
        end else begin
            o_entry = '0;
        end
    end

endmodule

// File: rtl/sccb_reg_sequencer.sv
// ---------------------------------------------------------------------------
// sccb_reg_sequencer
// Walks the init ROM on a start edge and issues one SCCB write per entry to
// the shared I2C master, with optional readback compare and per-entry retry.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : rising edge begins a sequence (ignored while active)
//   ena, rw         : master request / direction (0 = write)
//   addr            : device address (DEV_ADDR once a transfer is issued)
//   sub_addr,data_wr: register sub-address and write data
//   data_rd, busy,  : master read data, busy flag, NACK flag
//   ack_err
//   active          : sequence in progress
//   done, error     : sticky completion / failure flags
//   err_idx         : table index that exhausted its retries
// ---------------------------------------------------------------------------
module sccb_reg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [7:0]  DEV_ADDR    = SCCB_WR_ADDR,
    parameter int unsigned MAX_RETRIES = 3,
    parameter bit          VERIFY      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      ena,
    output logic                      rw,
    output logic [7:0]                addr,
    output logic [7:0]                sub_addr,
    output logic [7:0]                data_wr,
    input  logic [7:0]                data_rd,
    input  logic                      busy,
    input  logic                      ack_err,
    output logic                      active,
    output logic                      done,
    output logic                      error,
    output logic [$clog2(NUM_REGS):0] err_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS) + 1;
    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRIES);

    seq_state_e       r_state, w_state_nxt;
    logic             r_prev_start;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [RTY_W-1:0] r_retry, w_retry_nxt;
    logic             r_ena, w_ena_nxt;
    logic             r_rw, w_rw_nxt;
    logic [7:0]       r_addr, w_addr_nxt;
    logic [7:0]       r_sub_addr, w_sub_addr_nxt;
    logic [7:0]       r_data_wr, w_data_wr_nxt;
    logic             r_active, w_active_nxt;
    logic             r_done, w_done_nxt;
    logic             r_error, w_error_nxt;
    logic [IDX_W-1:0] r_err_idx, w_err_idx_nxt;

    logic             w_start_edge;
    logic             w_fail;
    reg_entry_t       w_entry;

    sccb_init_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    assign w_start_edge = start & ~r_prev_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_prev_start <= 1'b0;
            r_idx        <= '0;
            r_retry      <= '0;
            r_ena        <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_sub_addr   <= '0;
            r_data_wr    <= '0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_idx    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_start <= start;
            r_idx        <= w_idx_nxt;
            r_retry      <= w_retry_nxt;
            r_ena        <= w_ena_nxt;
            r_rw         <= w_rw_nxt;
            r_addr       <= w_addr_nxt;
            r_sub_addr   <= w_sub_addr_nxt;
            r_data_wr    <= w_data_wr_nxt;
            r_active     <= w_active_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_err_idx    <= w_err_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_retry_nxt    = r_retry;
        w_ena_nxt      = r_ena;
        w_rw_nxt       = r_rw;
        w_addr_nxt     = r_addr;
        w_sub_addr_nxt = r_sub_addr;
        w_data_wr_nxt  = r_data_wr;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_err_idx_nxt  = r_err_idx;
        w_fail         = 1'b0;

        case (r_state)
            StIdle, StDone, StFail: begin
                w_ena_nxt = 1'b0;
                if (w_start_edge) begin
                    w_done_nxt    = 1'b0;
                    w_error_nxt   = 1'b0;
                    w_err_idx_nxt = '0;
                    w_idx_nxt     = '0;
                    w_retry_nxt   = '0;
                    w_state_nxt   = StArm;
                end
            end
            StArm: begin
                w_ena_nxt = 1'b0;
                // Never touch a master that is still finishing an earlier transfer.
                if (!busy) begin
                    w_ena_nxt      = 1'b1;
                    w_rw_nxt       = 1'b0;
                    w_addr_nxt     = DEV_ADDR;
                    w_sub_addr_nxt = w_entry.sub_addr;
                    w_data_wr_nxt  = w_entry.data;
                    w_state_nxt    = StIssueWr;
                end
            end
            StIssueWr: begin
                if (busy) begin
                    w_ena_nxt   = 1'b0;
                    w_state_nxt = StWaitWr;
                end
            end
            StWaitWr: begin
                if (!busy) begin
                    if (ack_err) begin
                        w_fail = 1'b1;
                    end else if (VERIFY) begin
                        w_ena_nxt   = 1'b1;
                        w_rw_nxt    = 1'b1;
                        w_state_nxt = StIssueRd;
                    end else begin
                        w_state_nxt = StNext;
                    end
                end
            end
            StIssueRd: begin
                if (busy) begin
                    w_ena_nxt   = 1'b0;
                    w_state_nxt = StWaitRd;
                end
            end
            StWaitRd: begin
                if (!busy) begin
                    if (ack_err || (data_rd != w_entry.data)) begin
                        w_fail = 1'b1;
                    end else begin
                        w_state_nxt = StNext;
                    end
                end
            end
            StNext: begin
                if (r_idx == LAST_IDX) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StDone;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_retry_nxt = '0;
                    w_state_nxt = StArm;
                end
            end
            default: begin
                w_ena_nxt   = 1'b0;
                w_state_nxt = StIdle;
            end
        endcase

        // Shared NACK / readback-mismatch handling: retry same index or give up.
        if (w_fail) begin
            if (r_retry < RETRY_MAX) begin
                w_retry_nxt = r_retry + 1'b1;
                w_state_nxt = StArm;
            end else begin
                w_err_idx_nxt = r_idx;
                w_error_nxt   = 1'b1;
                w_state_nxt   = StFail;
            end
        end

        w_active_nxt = !((w_state_nxt == StIdle) || (w_state_nxt == StDone) ||
                         (w_state_nxt == StFail));
    end

    assign ena      = r_ena;
    assign rw       = r_rw;
    assign addr     = r_addr;
    assign sub_addr = r_sub_addr;
    assign data_wr  = r_data_wr;
    assign active   = r_active;
    assign done     = r_done;
    assign error    = r_error;
    assign err_idx  = r_err_idx;

endmodule

// File: doc/sccb_reg_sequencer.md
# sccb_reg_sequencer

Table-driven SCCB/I2C register-programming sequencer for the camera front end. On a start edge it walks a parametrised table of (sub-address, data) pairs, issuing one write per entry to the shared I2C master. Optional readback verification and per-entry retry on NACK or mismatch are provided. It reports completion or the failing table index to the capture control logic.

## Interface
- `NUM_REGS`, default 8: table entries, ≥1.
- `DEV_ADDR`, default 8'hC0: 8-bit SCCB device write address, R/W bit = 0.
- `MAX_RETRIES`, default 3: extra attempts per entry after a failure, ≥0.
- `VERIFY`, default 0: 1 = read back each entry after writing it and compare.
- `clk` in, 1: system clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `start` in, 1: rising edge begins the sequence.
- `ena` out, 1: transaction request to the I2C master.
- `rw` out, 1: 0 = write, 1 = read.
- `addr` out, 8: device address, always `DEV_ADDR` when active.
- `sub_addr` out, 8: register sub-address.
- `data_wr` out, 8: write data.
- `data_rd` in, 8: read data, valid when `busy` falls after a read.
- `busy` in, 1: master transaction in progress.
- `ack_err` in, 1: NACK flag, valid when `busy` falls.
- `active` out, 1: sequence in progress.
- `done` out, 1: all entries written successfully, sticky.
- `error` out, 1: an entry exhausted its retries, sticky.
- `err_idx` out, $clog2(NUM_REGS)+1: failing table index.

## Operation
- States: IDLE, ARM, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT, DONE, FAIL.
- Start detection:
  - `start` is registered into `prev_start`.
  - An edge is `start & ~prev_start`.
  - Edges are accepted only in IDLE, DONE or FAIL and are ignored while `active`.
  - An accepted edge clears `done`, `error` and `err_idx`, sets idx=0 and retry=0, and moves to ARM.
- ARM: waits until `busy`=0, so a master still busy after a mid-transfer reset is not disturbed. Then moves to ISSUE_WR.
- ISSUE_WR:
  - Drives `ena`=1, `rw`=0, `addr`=`DEV_ADDR`, and `sub_addr`/`data_wr` from table[idx].
  - When `busy`=1 is sampled: `ena`←0, move to WAIT_WR.
- WAIT_WR: on `busy`=0:
  - `ack_err`=1 → fail path.
  - else `VERIFY`=1 → ISSUE_RD.
  - else → NEXT.
- ISSUE_RD / WAIT_RD: same handshake with `rw`=1. On `busy` fall:
  - `ack_err`=1 or `data_rd`≠table[idx].data → fail path.
  - else → NEXT.
- Fail path:
  - If retry < `MAX_RETRIES`: retry++, return to ARM, same idx.
  - Else: `err_idx`←idx, `error`←1, → FAIL.
- NEXT:
  - If idx = `NUM_REGS`-1 → DONE with `done`←1.
  - Else idx++, retry←0, → ARM.
- The index never wraps. DONE and FAIL hold `ena`=0 until the next start edge.
- `active`=1 in every state except IDLE, DONE and FAIL.

## Timing
- All outputs are registered.
- Reset values: `ena`=0, `rw`=0, `addr`=0, `sub_addr`=0, `data_wr`=0, `active`=0, `done`=0, `error`=0, `err_idx`=0; state=IDLE, `prev_start`=0.
- Start latency:
  - Start edge sampled at cycle N → ARM at N+1.
  - With `busy`=0, `ena` is high from N+2.
- `ena` falls in the cycle after `busy` is first sampled high. The master must latch its request fields on the cycle it raises `busy`.
- `addr`, `sub_addr`, `data_wr` and `rw` remain stable from ISSUE until the next ISSUE.
- `ack_err` and `data_rd` are sampled only on the first cycle `busy` is seen low in WAIT_*.
- Inter-transaction gap: ≥2 cycles (NEXT or fail path, then ARM).
- A start edge arriving while `active` is dropped, even if `start` stays high afterward. Only a fresh edge after completion restarts the sequence.
- Reset mid-operation aborts immediately. `ena` drops asynchronously and the table position is lost.

## Structure
- Package `cam_cfg_pkg` holds:
  - the `reg_entry_t` struct {sub_addr[7:0], data[7:0]};
  - the default OV-series table constant: 11→04, 14→20, 39→40, 28→E0, 17→38, 18→6A, 19→03, 1A→35;
  - the `SCCB_WR_ADDR` = 8'hC0 constant.
- Sub-module `sccb_init_rom`:
  - parametrised by `NUM_REGS`;
  - combinational lookup idx → `reg_entry_t` from the package table;
  - replaceable per sensor.

## Test plan
- Default table, `VERIFY`=0, master model with 10-cycle busy and no NACK, start pulse → 8 writes in order with sub_addr 11,14,39,28,17,18,19,1A and data 04,20,40,E0,38,6A,03,35; `done`=1, `error`=0.
- `ack_err`=1 on entry 2 for two attempts, `MAX_RETRIES`=3 → entry 2 written 3 times total, then the sequence completes with `done`=1.
- `ack_err` stuck high on entry 5, `MAX_RETRIES`=3 → 4 attempts at 0x18, then `error`=1, `err_idx`=5, `done`=0, `ena`=0.
- `VERIFY`=1, model returns 0x21 when reading 0x14 once → write 0x14, read, mismatch, rewrite, read 0x20, continue; final `done`=1.
- Start held high through completion, second start pulse issued while `active` → no restart; a fresh pulse after `done` reruns from idx 0.
- Reset asserted during WAIT_WR with `busy` high → all outputs at reset values; after release and a start edge, `ena` stays low until `busy` falls.
